branch_resolve_unit: RTL and testbench

Parametrised, registered branch resolution unit for the multi-cycle MIPS datapath. It accepts one branch per handshake and evaluates signed MIPS branch conditions: BEQ, BNE, BLEZ, BGTZ, and REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL. It computes the branch target and link address. It also keeps a 2-bit saturating-counter pattern history table (PHT), reports the prediction for that PC, and flags mispredicts to the control FSM.

---
 rtl/branch_resolve_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Registered branch resolution for the multi-cycle MIPS datapath. Each
//   accepted request is evaluated against the signed MIPS branch conditions
//   (BEQ/BNE/BLEZ/BGTZ, REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL). The unit produces the
//   branch target and link address, reports the 2-bit PHT prediction for the
//   PC, and flags mispredicts.
//
//   Optional build macro: BRANCH_STATS_EN adds saturating branch/mispredict
//   counters. Without it both count ports are tied to zero.
//
// Ports
//   CLK, RST_N            clock (rising edge), async active-low reset
//   Req / Ready           request handshake, accepted only while Ready=1
//   SrcA, SrcB            rs / rt operands (signed)
//   OP, Branch_funct      opcode and REGIMM rt sub-op
//   PC, Offset            branch address and 16-bit immediate
//   Flush                 synchronous abort to IDLE
//   Valid / Ack           result handshake, result held until Ack
//   IsBranch .. LinkAddr  registered results
//   BranchCount, MispredictCount  statistics
//
// state | meaning
// IDLE  | ready, waiting for Req
// EVAL  | operands latched, resolve condition and update PHT
// DONE  | result valid, waiting for Ack
module branch_resolve_unit #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int PHT_IDX_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Req,
  output logic              Ready,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic [5:0]        OP,
  input  logic [4:0]        Branch_funct,
  input  logic [PC_W-1:0]   PC,
  input  logic [15:0]       Offset,
  input  logic              Flush,
  output logic              Valid,
  input  logic              Ack,
  output logic              IsBranch,
  output logic              BranchSucceed,
  output logic              Predicted,
  output logic              Mispredict,
  output logic [PC_W-1:0]   BranchTarget,
  output logic              LinkEn,
  output logic [PC_W-1:0]   LinkAddr,
  output logic [31:0]       BranchCount,
  output logic [31:0]       MispredictCount
);

  localparam int PHT_ENTRIES = 1 << PHT_IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_src_a;
  logic [DATA_W-1:0] r_src_b;
  logic [5:0]        r_op;
  logic [4:0]        r_funct;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_offset;

  logic              r_is_branch;
  logic              r_succeed;
  logic              r_predicted;
  logic              r_mispredict;
  logic [PC_W-1:0]   r_target;
  logic              r_link_en;
  logic [PC_W-1:0]   r_link_addr;

  logic [1:0]        r_pht [PHT_ENTRIES];

  logic                 w_accept;
  logic                 w_eval_fire;
  logic                 w_is_br;
  logic                 w_cond;
  logic                 w_link;
  logic                 w_a_eq_b;
  logic                 w_a_neg;
  logic                 w_a_zero;
  logic [PHT_IDX_W-1:0] w_idx;
  logic [1:0]           w_pht_val;
  logic [1:0]           w_pht_nxt;
  logic                 w_pred;
  logic                 w_misp;
  logic [PC_W-1:0]      w_sext_off;
  logic [PC_W-1:0]      w_target;
  logic [PC_W-1:0]      w_link_addr;

  // Flush outranks both Req and Ack.
  assign w_accept    = (r_state == S_IDLE) && Req && !Flush;
  assign w_eval_fire = (r_state == S_EVAL) && !Flush;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (Flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (Req) w_state_nxt = S_EVAL;
        S_EVAL:  w_state_nxt = S_DONE;
        S_DONE:  if (Ack) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign Ready = (r_state == S_IDLE);
  assign Valid = (r_state == S_DONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_src_a  <= '0;
      r_src_b  <= '0;
      r_op     <= '0;
      r_funct  <= '0;
      r_pc     <= '0;
      r_offset <= '0;
    end else if (w_accept) begin
      r_src_a  <= SrcA;
      r_src_b  <= SrcB;
      r_op     <= OP;
      r_funct  <= Branch_funct;
      r_pc     <= PC;
      r_offset <= Offset;
    end
  end

  // Signed compares against zero reduce to sign bit and zero detect.
  assign w_a_eq_b = (r_src_a == r_src_b);
  assign w_a_neg  = r_src_a[DATA_W-1];
  assign w_a_zero = (r_src_a == '0);

  always_comb begin
    w_is_br = 1'b0;
    w_cond  = 1'b0;
    w_link  = 1'b0;
    case (r_op)
      6'b000100: begin w_is_br = 1'b1; w_cond = w_a_eq_b;             end
      6'b000101: begin w_is_br = 1'b1; w_cond = !w_a_eq_b;            end
      6'b000110: begin w_is_br = 1'b1; w_cond = w_a_neg || w_a_zero;  end
      6'b000111: begin w_is_br = 1'b1; w_cond = !w_a_neg && !w_a_zero; end
      6'b000001: begin
        case (r_funct)
          5'b00000: begin w_is_br = 1'b1; w_cond = w_a_neg;  end
          5'b00001: begin w_is_br = 1'b1; w_cond = !w_a_neg; end
          5'b10000: begin w_is_br = 1'b1; w_cond = w_a_neg;  w_link = 1'b1; end
          5'b10001: begin w_is_br = 1'b1; w_cond = !w_a_neg; w_link = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign w_idx     = r_pc[PHT_IDX_W+1:2];
  assign w_pht_val = r_pht[w_idx];
  assign w_pred    = w_pht_val[1];
  assign w_misp    = w_is_br && (w_pred != w_cond);

  always_comb begin
    w_pht_nxt = w_pht_val;
    if (w_cond) begin
      if (w_pht_val != 2'b11) w_pht_nxt = w_pht_val + 2'b01;
    end else begin
      if (w_pht_val != 2'b00) w_pht_nxt = w_pht_val - 2'b01;
    end
  end

  assign w_sext_off  = {{(PC_W-16){r_offset[15]}}, r_offset};
  assign w_target    = r_pc + PC_W'(4) + (w_sext_off << 2);
  assign w_link_addr = r_pc + PC_W'(8);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= 2'b01;
    end else if (w_eval_fire && w_is_br) begin
      r_pht[w_idx] <= w_pht_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_is_branch  <= 1'b0;
      r_succeed    <= 1'b0;
      r_predicted  <= 1'b0;
      r_mispredict <= 1'b0;
      r_target     <= '0;
      r_link_en    <= 1'b0;
      r_link_addr  <= '0;
    end else if (w_eval_fire) begin
      r_is_branch  <= w_is_br;
      r_succeed    <= w_is_br && w_cond;
      r_predicted  <= w_pred;
      r_mispredict <= w_misp;
      r_target     <= w_target;
      r_link_en    <= w_link;
      r_link_addr  <= w_link_addr;
    end
  end

  assign IsBranch      = r_is_branch;
  assign BranchSucceed = r_succeed;
  assign Predicted     = r_predicted;
  assign Mispredict    = r_mispredict;
  assign BranchTarget  = r_target;
  assign LinkEn        = r_link_en;
  assign LinkAddr      = r_link_addr;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_mp_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else if (w_eval_fire && w_is_br) begin
      if (r_br_cnt != 32'hFFFF_FFFF) r_br_cnt <= r_br_cnt + 32'd1;
      if (w_misp && (r_mp_cnt != 32'hFFFF_FFFF)) r_mp_cnt <= r_mp_cnt + 32'd1;
    end
  end

  assign BranchCount     = r_br_cnt;
  assign MispredictCount = r_mp_cnt;
`else
  assign BranchCount     = '0;
  assign MispredictCount = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Req, Ready, Flush, Valid, Ack;
  logic [31:0] SrcA, SrcB, PC;
  logic [5:0]  OP;
  logic [4:0]  Branch_funct;
  logic [15:0] Offset;
  logic        IsBranch, BranchSucceed, Predicted, Mispredict, LinkEn;
  logic [31:0] BranchTarget, LinkAddr, BranchCount, MispredictCount;

  branch_resolve_unit dut (
    .CLK(CLK), .RST_N(RST_N), .Req(Req), .Ready(Ready),
    .SrcA(SrcA), .SrcB(SrcB), .OP(OP), .Branch_funct(Branch_funct),
    .PC(PC), .Offset(Offset), .Flush(Flush), .Valid(Valid), .Ack(Ack),
    .IsBranch(IsBranch), .BranchSucceed(BranchSucceed), .Predicted(Predicted),
    .Mispredict(Mispredict), .BranchTarget(BranchTarget), .LinkEn(LinkEn),
    .LinkAddr(LinkAddr), .BranchCount(BranchCount),
    .MispredictCount(MispredictCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  funct;
    logic [31:0] a, b, pc;
    logic [15:0] off;
    logic        br, succ, link;
  } vec_t;

  typedef struct {
    logic        br, succ, pred, misp, link;
    logic [31:0] target, laddr, bc, mc;
  } exp_t;

  vec_t  vecs[17];
  exp_t  sb_q[$];
  logic [1:0]  pht_m[16];
  logic [31:0] br_cnt_m, mp_cnt_m, last_target;
  int    n_cmp = 0;
  int    n_err = 0;
  string tag = "";

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pht_m[i] = 2'b01;
    br_cnt_m = 0; mp_cnt_m = 0; last_target = 0;
    sb_q.delete();
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] f,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [15:0] off,
                              input logic br, input logic succ, input logic link);
    vec_t v;
    v.op = op; v.funct = f; v.a = a; v.b = b; v.pc = pc; v.off = off;
    v.br = br; v.succ = succ; v.link = link;
    return v;
  endfunction

  // Drive the inputs, raise Req and push the expected result.
  task automatic drive_req(input vec_t v);
    exp_t e;
    logic [3:0] idx;
    OP = v.op; Branch_funct = v.funct; SrcA = v.a; SrcB = v.b;
    PC = v.pc; Offset = v.off; Req = 1'b1;
    idx      = v.pc[5:2];
    e.br     = v.br;
    e.succ   = v.succ;
    e.link   = v.link;
    e.target = v.pc + 32'd4 + {{14{v.off[15]}}, v.off, 2'b00};
    e.laddr  = v.pc + 32'd8;
    e.pred   = pht_m[idx][1];
    e.misp   = v.br && (e.pred != v.succ);
    if (v.br) begin
      if (v.succ && pht_m[idx] != 2'b11) pht_m[idx] = pht_m[idx] + 2'b01;
      if (!v.succ && pht_m[idx] != 2'b00) pht_m[idx] = pht_m[idx] - 2'b01;
      if (br_cnt_m != 32'hFFFF_FFFF) br_cnt_m++;
      if (e.misp && mp_cnt_m != 32'hFFFF_FFFF) mp_cnt_m++;
    end
`ifdef BRANCH_STATS_EN
    e.bc = br_cnt_m; e.mc = mp_cnt_m;
`else
    e.bc = 0; e.mc = 0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!Valid && n < 8) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    chk("valid", Valid, 1);
    chk("isbr", IsBranch, e.br);
    chk("succ", BranchSucceed, e.succ);
    chk("pred", Predicted, e.pred);
    chk("misp", Mispredict, e.misp);
    chk("target", BranchTarget, e.target);
    chk("linken", LinkEn, e.link);
    chk("linkaddr", LinkAddr, e.laddr);
    chk("bcount", BranchCount, e.bc);
    chk("mcount", MispredictCount, e.mc);
    last_target = e.target;
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    @(posedge CLK); #1;
    Ack = 1'b0;
    chk("ready_after_ack", Ready, 1);
    chk("valid_after_ack", Valid, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    drive_req(v);
    @(posedge CLK); #1;
    Req = 1'b0;
    chk("ready_in_eval", Ready, 0);
    wait_valid(n);
    chk("latency", n, 1);
    check_out();
    do_ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t v;
    RST_N = 1'b0; Req = 0; Ack = 0; Flush = 0;
    SrcA = 0; SrcB = 0; PC = 0; OP = 0; Branch_funct = 0; Offset = 0;
    model_reset();

    vecs[0]  = mk(6'h04, 5'h00, 32'h5,        32'h5, 32'h100,      16'hFFFF, 1, 1, 0);
    vecs[1]  = mk(6'h05, 5'h00, 32'h5,        32'h6, 32'h104,      16'h0010, 1, 1, 0);
    vecs[2]  = mk(6'h05, 5'h00, 32'h7,        32'h7, 32'h108,      16'h0010, 1, 0, 0);
    vecs[3]  = mk(6'h06, 5'h00, 32'h80000000, 32'h0, 32'h10C,      16'h0004, 1, 1, 0);
    vecs[4]  = mk(6'h07, 5'h00, 32'h80000000, 32'h0, 32'h110,      16'h0004, 1, 0, 0);
    vecs[5]  = mk(6'h06, 5'h00, 32'h0,        32'h0, 32'h114,      16'h8000, 1, 1, 0);
    vecs[6]  = mk(6'h07, 5'h00, 32'h1,        32'h0, 32'h118,      16'h0001, 1, 1, 0);
    vecs[7]  = mk(6'h01, 5'h00, 32'hFFFFFFFF, 32'h0, 32'h11C,      16'h0002, 1, 1, 0);
    vecs[8]  = mk(6'h01, 5'h01, 32'h0,        32'h0, 32'h120,      16'h0003, 1, 1, 0);
    vecs[9]  = mk(6'h01, 5'h11, 32'hFFFFFFFF, 32'h0, 32'h200,      16'h0004, 1, 0, 1);
    vecs[10] = mk(6'h01, 5'h10, 32'h80000000, 32'h0, 32'h204,      16'h0004, 1, 1, 1);
    vecs[11] = mk(6'h23, 5'h00, 32'h0,        32'h0, 32'h300,      16'h0004, 0, 0, 0);
    vecs[12] = mk(6'h01, 5'h02, 32'hFFFFFFFF, 32'h0, 32'h304,      16'h0004, 0, 0, 0);
    vecs[13] = mk(6'h04, 5'h00, 32'h3,        32'h3, 32'hFFFFFFF0, 16'h7FFF, 1, 1, 0);
    vecs[14] = mk(6'h04, 5'h00, 32'h1,        32'h2, 32'h100,      16'hFFFF, 1, 0, 0);
    vecs[15] = mk(6'h07, 5'h00, 32'h0,        32'h0, 32'h124,      16'h0000, 1, 0, 0);
    vecs[16] = mk(6'h01, 5'h00, 32'h0,        32'h0, 32'h128,      16'h0000, 1, 0, 0);

    #12;
    tag = "reset";
    chk("ready", Ready, 1);
    chk("valid", Valid, 0);
    chk("isbr", IsBranch, 0);
    chk("target", BranchTarget, 0);
    chk("linkaddr", LinkAddr, 0);
    chk("bcount", BranchCount, 0);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 17; i++) begin
      tag = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end

    // Req held while DONE and un-acked: ignored, outputs stable.
    tag = "hold";
    v = mk(6'h05, 5'h00, 32'h1, 32'h2, 32'h400, 16'h0020, 1, 1, 0);
    drive_req(v);
    @(posedge CLK); #1;
    SrcA = 32'h9; SrcB = 32'h9; PC = 32'h500; Offset = 16'h1234;
    wait_valid(n);
    chk("latency", n, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      chk("held_valid", Valid, 1);
      chk("held_ready", Ready, 0);
      chk("held_target", BranchTarget, 32'h484);
    end
    check_out();
    Req = 1'b0;
    do_ack();

    // Flush in EVAL: no result, PHT and stats untouched, outputs keep values.
    tag = "flush_eval";
    OP = 6'h04; Branch_funct = 0; SrcA = 32'h1; SrcB = 32'h1; PC = 32'h80; Offset = 16'h0;
    Req = 1'b1;
    @(posedge CLK); #1;
    Req = 1'b0; Flush = 1'b1;
    @(posedge CLK); #1;
    Flush = 1'b0;
    chk("ready", Ready, 1);
    chk("valid", Valid, 0);
    chk("target_kept", BranchTarget, last_target);
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      chk("valid_stays_low", Valid, 0);
    end
    tag = "after_flush";
    run_vec(mk(6'h04, 5'h00, 32'h1, 32'h1, 32'h80, 16'h0, 1, 1, 0));

    // Flush in DONE drops Valid and returns to IDLE.
    tag = "flush_done";
    drive_req(mk(6'h04, 5'h00, 32'h2, 32'h3, 32'hC4, 16'h0, 1, 0, 0));
    @(posedge CLK); #1;
    Req = 1'b0;
    wait_valid(n);
    check_out();
    Flush = 1'b1; Ack = 1'b1;
    @(posedge CLK); #1;
    Flush = 1'b0; Ack = 1'b0;
    chk("valid", Valid, 0);
    chk("ready", Ready, 1);

    // Reset mid-EVAL: immediate return to reset values, PHT cleared.
    tag = "reset_mid";
    OP = 6'h04; SrcA = 32'h1; SrcB = 32'h1; PC = 32'h40; Req = 1'b1;
    @(posedge CLK); #1;
    Req = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("ready", Ready, 1);
    chk("valid", Valid, 0);
    chk("target", BranchTarget, 0);
    chk("succ", BranchSucceed, 0);
    chk("bcount", BranchCount, 0);
    model_reset();
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;

    // PHT saturation at PC 0x40: taken x4 then not-taken x3.
    for (int k = 0; k < 4; k++) begin
      tag = $sformatf("sat_taken%0d", k);
      run_vec(mk(6'h04, 5'h00, 32'h9, 32'h9, 32'h40, 16'h0001, 1, 1, 0));
    end
    for (int k = 0; k < 3; k++) begin
      tag = $sformatf("sat_nt%0d", k);
      run_vec(mk(6'h04, 5'h00, 32'h9, 32'h8, 32'h40, 16'h0001, 1, 0, 0));
    end

    tag = "end";
    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
